// File: rtl/anim_sequencer_pkg.sv
// Shared types and default constants for the per-frame animation sequencer
// and the renderer that consumes its outputs.
package anim_pkg;

  localparam int TEXT_Y0_DEF        = 20;
  localparam int TEXT_Y_END_DEF     = 276;
  localparam int WAIT_FRAMES_DEF    = 256;
  localparam int SWALLOW_FRAMES_DEF = 64;
  localparam int TEXT_H             = 32;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_FALL    = 2'd1,
    ST_SWALLOW = 2'd2
  } text_state_t;

endpackage

// File: rtl/anim_sequencer_if.sv
// Bundle between the timing generator / control side and the sequencer.
interface anim_sequencer_if;

  // vsync is an active-low level from the timing generator; frame_tick is a
  // one-cycle pulse and every other output is a registered level that only
  // changes on the cycle frame_tick is high. There is no backpressure.
  logic                 vsync;
  logic                 pause;
  logic [1:0]           speed;
  logic                 frame_tick;
  logic [15:0]          frame_cnt;
  logic [7:0]           ring_phase;
  logic [9:0]           text_y;
  logic                 text_visible;
  anim_pkg::text_state_t text_state;

  modport master (
    output vsync, pause, speed,
    input  frame_tick, frame_cnt, ring_phase, text_y, text_visible, text_state
  );

  modport slave (
    input  vsync, pause, speed,
    output frame_tick, frame_cnt, ring_phase, text_y, text_visible, text_state
  );

endinterface

// File: rtl/frame_tick_gen.sv
// Detects the end of the vsync pulse and produces an update enable plus a
// registered frame_tick that rises on the same edge the enable is consumed.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic tick_en_o,
  output logic frame_tick_o
);

  logic vsync_prev_q;
  logic rise_q;
  logic frame_tick_q;

  // vsync_prev resets high so a vsync already high at release is no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_prev_q <= 1'b1;
      rise_q       <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      vsync_prev_q <= vsync_i;
      rise_q       <= vsync_i & ~vsync_prev_q;
      frame_tick_q <= rise_q;
    end
  end

  assign tick_en_o    = rise_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/anim_sequencer.sv
// Frame-rate state for the renderer: frame counter, ring phase and the
// WAIT/FALL/SWALLOW falling-text sequence, all updated once per frame tick.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int TEXT_Y0        = TEXT_Y0_DEF,
  parameter int TEXT_Y_END     = TEXT_Y_END_DEF,
  parameter int WAIT_FRAMES    = WAIT_FRAMES_DEF,
  parameter int SWALLOW_FRAMES = SWALLOW_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  anim_sequencer_if.slave  bus
);

  localparam logic [9:0] Y0           = 10'(TEXT_Y0);
  localparam logic [9:0] Y_END        = 10'(TEXT_Y_END);
  localparam logic [7:0] WAIT_LAST    = 8'(WAIT_FRAMES - 1);
  localparam logic [7:0] SWALLOW_LAST = 8'(SWALLOW_FRAMES - 1);

  logic        tick_en;
  logic        frame_tick;

  text_state_t state_q, state_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  ring_q, ring_d;
  logic [9:0]  text_y_q, text_y_d;
  logic        visible_q, visible_d;
  logic [7:0]  dwell_q, dwell_d;
  logic [10:0] fall_sum;

  frame_tick_gen u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .vsync_i      (bus.vsync),
    .tick_en_o    (tick_en),
    .frame_tick_o (frame_tick)
  );

  // One bit of headroom so a large step never wraps past the clamp.
  assign fall_sum = {1'b0, text_y_q} + {9'd0, bus.speed} + 11'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      frame_cnt_q <= 16'd0;
      ring_q      <= 8'd0;
      text_y_q    <= Y0;
      visible_q   <= 1'b1;
      dwell_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      ring_q      <= ring_d;
      text_y_q    <= text_y_d;
      visible_q   <= visible_d;
      dwell_q     <= dwell_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    ring_d      = ring_q;
    text_y_d    = text_y_q;
    visible_d   = visible_q;
    dwell_d     = dwell_q;
    if (tick_en) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (!bus.pause) begin
        ring_d = ring_q + 8'd1;
        case (state_q)
          ST_WAIT: begin
            text_y_d  = Y0;
            visible_d = 1'b1;
            if (dwell_q == WAIT_LAST) begin
              state_d = ST_FALL;
              dwell_d = 8'd0;
            end else begin
              dwell_d = dwell_q + 8'd1;
            end
          end
          ST_FALL: begin
            if (fall_sum >= {1'b0, Y_END}) begin
              text_y_d  = Y_END;
              state_d   = ST_SWALLOW;
              visible_d = 1'b0;
              dwell_d   = 8'd0;
            end else begin
              text_y_d = fall_sum[9:0];
            end
          end
          ST_SWALLOW: begin
            visible_d = 1'b0;
            if (dwell_q == SWALLOW_LAST) begin
              state_d   = ST_WAIT;
              text_y_d  = Y0;
              visible_d = 1'b1;
              dwell_d   = 8'd0;
            end else begin
              dwell_d = dwell_q + 8'd1;
            end
          end
          default: begin
            state_d   = ST_WAIT;
            text_y_d  = Y0;
            visible_d = 1'b1;
            dwell_d   = 8'd0;
          end
        endcase
      end
    end
  end

  assign bus.frame_tick   = frame_tick;
  assign bus.frame_cnt    = frame_cnt_q;
  assign bus.ring_phase   = ring_q;
  assign bus.text_y       = text_y_q;
  assign bus.text_visible = visible_q;
  assign bus.text_state   = state_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: randomized vsync pulses and control
// inputs checked against a frame-level behavioural model.
module tb_anim_sequencer;
  import anim_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  anim_sequencer_if bus ();

  anim_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: phase 0=WAIT 1=FALL 2=SWALLOW, counted in whole frames.
  int m_frames, m_ring, m_y, m_phase, m_count;

  task automatic model_reset();
    m_frames = 0; m_ring = 0; m_y = 20; m_phase = 0; m_count = 0;
  endtask

  task automatic model_tick();
    m_frames = (m_frames + 1) % 65536;
    if (!bus.pause) begin
      m_ring = (m_ring + 1) % 256;
      if (m_phase == 0) begin
        m_count++;
        if (m_count == 256) begin m_phase = 1; m_count = 0; end
      end else if (m_phase == 1) begin
        m_y = m_y + int'(bus.speed) + 1;
        if (m_y >= 276) begin m_y = 276; m_phase = 2; m_count = 0; end
      end else begin
        m_count++;
        if (m_count == 64) begin m_phase = 0; m_y = 20; m_count = 0; end
      end
    end
  endtask

  function automatic logic [37:0] exp_vec(input logic tick);
    exp_vec = {tick, 16'(m_frames), 8'(m_ring), 10'(m_y), (m_phase != 2), 2'(m_phase)};
  endfunction

  function automatic logic [37:0] obs_vec();
    obs_vec = {bus.frame_tick, bus.frame_cnt, bus.ring_phase, bus.text_y,
               bus.text_visible, 2'(bus.text_state)};
  endfunction

  // Starts and ends on a falling clock edge; returns on the frame_tick cycle.
  task automatic do_tick(input int low_cyc);
    bus.vsync = 1'b0;
    repeat (low_cyc) @(negedge clk);
    bus.vsync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_tick();
  endtask

  task automatic test_reset();
    int seen;
    seen = 0;
    bus.vsync = 1'b1; bus.pause = 1'b0; bus.speed = 2'd0;
    rst_n = 1'b0;
    model_reset();
    #23;
    checks++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      failures++; $display("FAIL reset_values obs=%h exp=%h", obs_vec(), exp_vec(1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (bus.frame_tick !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL reset_no_tick ticks=%0d exp=0", seen);
    end
    checks++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      failures++; $display("FAIL reset_hold obs=%h exp=%h", obs_vec(), exp_vec(1'b0));
    end
  endtask

  task automatic test_wait_to_fall();
    bus.pause = 1'b0; bus.speed = 2'd0;
    for (int i = 0; i < 256; i++) begin
      do_tick($urandom_range(1, 3));
      checks++;
      if (obs_vec() !== exp_vec(1'b1)) begin
        failures++; $display("FAIL wait_tick%0d obs=%h exp=%h", i, obs_vec(), exp_vec(1'b1));
      end
    end
    checks++;
    if ({bus.frame_cnt, bus.ring_phase, bus.text_y, 2'(bus.text_state)} !==
        {16'd256, 8'd0, 10'd20, 2'd1}) begin
      failures++;
      $display("FAIL wait_end cnt=%0d ring=%0d y=%0d st=%0d exp 256/0/20/1",
               bus.frame_cnt, bus.ring_phase, bus.text_y, bus.text_state);
    end
  endtask

  task automatic test_fall_clamp();
    bus.speed = 2'd3;
    for (int i = 0; i < 100 && m_y < 272; i++) begin
      do_tick($urandom_range(1, 3));
      checks++;
      if (obs_vec() !== exp_vec(1'b1)) begin
        failures++; $display("FAIL fall_tick%0d obs=%h exp=%h", i, obs_vec(), exp_vec(1'b1));
      end
    end
    checks++;
    if (bus.text_y !== 10'd272) begin
      failures++; $display("FAIL fall_pre_clamp y=%0d exp=272", bus.text_y);
    end
    do_tick(1);
    checks++;
    if ({bus.text_y, bus.text_visible, 2'(bus.text_state)} !== {10'd276, 1'b0, 2'd2}) begin
      failures++;
      $display("FAIL fall_clamp y=%0d vis=%0d st=%0d exp 276/0/2",
               bus.text_y, bus.text_visible, bus.text_state);
    end
  endtask

  task automatic test_swallow();
    for (int i = 0; i < 64; i++) begin
      bus.speed = 2'($urandom_range(0, 3));
      do_tick($urandom_range(1, 2));
      checks++;
      if (obs_vec() !== exp_vec(1'b1)) begin
        failures++; $display("FAIL swallow_tick%0d obs=%h exp=%h", i, obs_vec(), exp_vec(1'b1));
      end
    end
    checks++;
    if ({bus.text_y, bus.text_visible, 2'(bus.text_state)} !== {10'd20, 1'b1, 2'd0}) begin
      failures++;
      $display("FAIL swallow_exit y=%0d vis=%0d st=%0d exp 20/1/0",
               bus.text_y, bus.text_visible, bus.text_state);
    end
  endtask

  task automatic test_pause();
    logic [15:0] fc;
    logic [7:0]  rp;
    bus.pause = 1'b0; bus.speed = 2'd0;
    repeat (256) do_tick(1);
    bus.speed = 2'd3;
    repeat (20) do_tick(1);
    checks++;
    if ({bus.text_y, 2'(bus.text_state)} !== {10'd100, 2'd1}) begin
      failures++; $display("FAIL pause_setup y=%0d st=%0d exp 100/1", bus.text_y, bus.text_state);
    end
    fc = bus.frame_cnt; rp = bus.ring_phase;
    bus.pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.speed = 2'($urandom_range(0, 3));
      do_tick($urandom_range(1, 3));
      checks++;
      if (obs_vec() !== exp_vec(1'b1)) begin
        failures++; $display("FAIL pause_tick%0d obs=%h exp=%h", i, obs_vec(), exp_vec(1'b1));
      end
    end
    checks++;
    if ({bus.frame_cnt, bus.ring_phase, bus.text_y, 2'(bus.text_state)} !==
        {fc + 16'd10, rp, 10'd100, 2'd1}) begin
      failures++;
      $display("FAIL pause_hold cnt=%0d ring=%0d y=%0d st=%0d exp %0d/%0d/100/1",
               bus.frame_cnt, bus.ring_phase, bus.text_y, bus.text_state, fc + 16'd10, rp);
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_reset_mid_fall();
    int seen;
    seen = 0;
    bus.speed = 2'd1;
    repeat (3) do_tick(1);
    bus.vsync = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      failures++; $display("FAIL async_reset obs=%h exp=%h", obs_vec(), exp_vec(1'b0));
    end
    @(negedge clk);
    bus.vsync = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.frame_tick !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || obs_vec() !== exp_vec(1'b0)) begin
      failures++; $display("FAIL post_reset_quiet ticks=%0d obs=%h exp=%h", seen, obs_vec(), exp_vec(1'b0));
    end
    do_tick(2);
    checks++;
    if (obs_vec() !== exp_vec(1'b1)) begin
      failures++; $display("FAIL first_tick_after_reset obs=%h exp=%h", obs_vec(), exp_vec(1'b1));
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    m_frames = 16'hFFFF;
    checks++;
    if (obs_vec() !== exp_vec(1'b0)) begin
      failures++; $display("FAIL wrap_preload obs=%h exp=%h", obs_vec(), exp_vec(1'b0));
    end
    do_tick(1);
    checks++;
    if (bus.frame_cnt !== 16'h0000 || obs_vec() !== exp_vec(1'b1)) begin
      failures++; $display("FAIL wrap cnt=%h obs=%h exp=%h", bus.frame_cnt, obs_vec(), exp_vec(1'b1));
    end
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 300; i++) begin
      bus.pause = ($urandom_range(0, 3) == 0);
      bus.speed = 2'($urandom_range(0, 3));
      do_tick($urandom_range(1, 4));
      checks++;
      if (obs_vec() !== exp_vec(1'b1)) begin
        failures++; $display("FAIL rand_tick%0d obs=%h exp=%h", i, obs_vec(), exp_vec(1'b1));
      end
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if (obs_vec() !== exp_vec(1'b0)) begin
          failures++; $display("FAIL rand_idle%0d obs=%h exp=%h", i, obs_vec(), exp_vec(1'b0));
        end
      end
    end
    bus.pause = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.speed = 2'd2;
    for (int i = 0; i < 20; i++) begin
      do_tick(1);
      checks++;
      if (obs_vec() !== exp_vec(1'b1)) begin
        failures++; $display("FAIL b2b_tick%0d obs=%h exp=%h", i, obs_vec(), exp_vec(1'b1));
      end
      @(negedge clk);
      checks++;
      if (bus.frame_tick !== 1'b0) begin
        failures++; $display("FAIL b2b_pulse_width%0d tick=%b exp=0", i, bus.frame_tick);
      end
    end
  endtask

  initial begin
    test_reset();
    test_wait_to_fall();
    test_fall_clamp();
    test_swallow();
    test_pause();
    test_reset_mid_fall();
    test_wrap();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
